// File: rtl/modulo_demux_seq.sv
// modulo_demux_seq
//   Registered 1-to-N demultiplexer with per-channel hold registers.
//   A write (E=1, CLR=0) routes D to one channel. The channel comes from S
//   (MODE=0) or from an internal scan pointer (MODE=1). In scan mode the
//   pointer advances after every accepted write.
//
// Parameters
//   SEL_W   select width; channel count N = 2**SEL_W
//   DATA_W  data width per channel
//   REVERSE 1: select c drives channel N-1-c; 0: select c drives channel c
//
// Ports
//   CLK    clock; all state changes on the rising edge
//   RST_N  asynchronous active-low reset
//   E      write enable
//   D      write data
//   S      channel select used in addressed mode
//   MODE   0 = addressed, 1 = scan
//   CLR    synchronous clear; overrides a simultaneous write
//   Y      hold registers; channel k at [k*DATA_W +: DATA_W]
//   V      one-cycle write strobe (one-hot or zero)
//   OCC    sticky per-channel written flags
//   PTR    scan pointer
module modulo_demux_seq #(
    parameter int SEL_W   = 4,
    parameter int DATA_W  = 1,
    parameter int REVERSE = 1
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        E,
    input  logic [DATA_W-1:0]           D,
    input  logic [SEL_W-1:0]            S,
    input  logic                        MODE,
    input  logic                        CLR,
    output logic [(2**SEL_W)*DATA_W-1:0] Y,
    output logic [2**SEL_W-1:0]          V,
    output logic [2**SEL_W-1:0]          OCC,
    output logic [SEL_W-1:0]            PTR
);

    localparam int unsigned N = 2**SEL_W;

    logic                     accept;
    logic [SEL_W-1:0]         sel_c;
    logic [SEL_W-1:0]         chan_k;
    logic [N-1:0]             onehot;
    logic [N*DATA_W-1:0]      y_next;

    always_comb begin
        accept = E & ~CLR;
        sel_c  = MODE ? PTR : S;
        // N is a power of two, so N-1-c is the bitwise complement of c.
        chan_k = (REVERSE != 0) ? ~sel_c : sel_c;
        onehot = '0;
        y_next = Y;
        for (int unsigned i = 0; i < N; i++) begin
            onehot[i] = (chan_k == SEL_W'(i));
            if (accept && onehot[i]) begin
                y_next[i*DATA_W +: DATA_W] = D;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Y   <= '0;
            V   <= '0;
            OCC <= '0;
            PTR <= '0;
        end else if (CLR) begin
            Y   <= '0;
            V   <= '0;
            OCC <= '0;
            PTR <= '0;
        end else if (accept) begin
            Y   <= y_next;
            V   <= onehot;
            OCC <= OCC | onehot;
            if (MODE) begin
                PTR <= PTR + 1'b1;
            end
        end else begin
            V <= '0;
        end
    end

endmodule

// File: tb/tb_modulo_demux_seq.sv
module tb_modulo_demux_seq;

    logic         clk;

    // Instance A: SEL_W=4, DATA_W=8, REVERSE=1
    logic         a_rst_n, a_e, a_mode, a_clr;
    logic [7:0]   a_d;
    logic [3:0]   a_s;
    logic [127:0] a_y;
    logic [15:0]  a_v, a_occ;
    logic [3:0]   a_ptr;

    // Instance B: SEL_W=2, DATA_W=1, REVERSE=0
    logic         b_rst_n, b_e, b_mode, b_clr;
    logic [0:0]   b_d;
    logic [1:0]   b_s;
    logic [3:0]   b_y, b_v, b_occ;
    logic [1:0]   b_ptr;

    int compared;
    int mismatched;

    modulo_demux_seq #(.SEL_W(4), .DATA_W(8), .REVERSE(1)) dut_a (
        .CLK(clk), .RST_N(a_rst_n), .E(a_e), .D(a_d), .S(a_s), .MODE(a_mode),
        .CLR(a_clr), .Y(a_y), .V(a_v), .OCC(a_occ), .PTR(a_ptr)
    );

    modulo_demux_seq #(.SEL_W(2), .DATA_W(1), .REVERSE(0)) dut_b (
        .CLK(clk), .RST_N(b_rst_n), .E(b_e), .D(b_d), .S(b_s), .MODE(b_mode),
        .CLR(b_clr), .Y(b_y), .V(b_v), .OCC(b_occ), .PTR(b_ptr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] slice8(input logic [127:0] y, input int k);
        return y[k*8 +: 8];
    endfunction

    initial begin
        compared   = 0;
        mismatched = 0;
        a_rst_n = 1'b0; a_e = 1'b0; a_mode = 1'b0; a_clr = 1'b0; a_d = '0; a_s = '0;
        b_rst_n = 1'b0; b_e = 1'b0; b_mode = 1'b0; b_clr = 1'b0; b_d = '0; b_s = '0;

        // Reset state
        #2;
        check("rst_y",   a_y,   '0);
        check("rst_v",   a_v,   '0);
        check("rst_occ", a_occ, '0);
        check("rst_ptr", a_ptr, '0);
        check("b_rst_y", b_y,   '0);
        tick();
        tick();
        #2;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // Addressed map: S=c lands on channel 15-c
        a_mode = 1'b0;
        for (int c = 0; c < 16; c++) begin
            a_s = 4'(c);
            a_d = 8'(8'h10 + c);
            a_e = 1'b1;
            tick();
            check("addr_v",   a_v, 128'(16'h8000 >> c));
            check("addr_y",   slice8(a_y, 15 - c), 128'(8'h10 + c));
            check("addr_ptr", a_ptr, '0);
        end
        a_e = 1'b0;
        tick();
        check("addr_v_idle", a_v,   '0);
        check("addr_occ",    a_occ, 128'(16'hFFFF));
        check("addr_y_full", a_y,   128'h10_11_12_13_14_15_16_17_18_19_1A_1B_1C_1D_1E_1F);

        // CLR beats a simultaneous write
        a_mode = 1'b1; a_e = 1'b1; a_clr = 1'b1; a_d = 8'hAA;
        tick();
        check("clr_y",   a_y,   '0);
        check("clr_occ", a_occ, '0);
        check("clr_ptr", a_ptr, '0);
        check("clr_v",   a_v,   '0);
        a_clr = 1'b0;

        // Scan wrap: 17 writes D=1..17
        a_mode = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            a_d = 8'(i);
            a_e = 1'b1;
            tick();
            check("scan_ptr", a_ptr, 128'(i % 16));
            check("scan_v",   a_v,   128'(16'h8000 >> ((i - 1) % 16)));
        end
        a_e = 1'b0;
        tick();
        check("scan_v_idle", a_v, '0);
        check("scan_y", a_y, 128'h11_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10);
        check("scan_ptr_hold", a_ptr, 128'd1);

        // Mode toggle keeps PTR; addressed write does not move it
        a_mode = 1'b0; a_s = 4'd3; a_d = 8'h55; a_e = 1'b1;
        tick();
        check("tog_ptr", a_ptr, 128'd1);
        check("tog_y12", slice8(a_y, 12), 128'h55);
        check("tog_v",   a_v, 128'h1000);
        a_mode = 1'b1; a_e = 1'b0;
        tick();
        check("tog_ptr2", a_ptr, 128'd1);

        // Clear alone, then scan with gaps E=1,0,1
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        a_mode = 1'b1; a_e = 1'b1; a_d = 8'h21;
        tick();
        check("gap_ptr0", a_ptr, 128'd1);
        check("gap_v0",   a_v,   128'h8000);
        a_e = 1'b0; a_d = 8'h22;
        tick();
        check("gap_ptr1", a_ptr, 128'd1);
        check("gap_v1",   a_v,   '0);
        a_e = 1'b1; a_d = 8'h23;
        tick();
        check("gap_ptr2", a_ptr, 128'd2);
        check("gap_v2",   a_v,   128'h4000);
        check("gap_y",    a_y,   128'h21_23 << 112);

        // Advance to PTR=5, then asynchronous reset between edges
        for (int i = 0; i < 3; i++) begin
            a_d = 8'(8'h30 + i);
            tick();
        end
        check("pre_rst_ptr", a_ptr, 128'd5);
        #3;
        a_rst_n = 1'b0;
        #1;
        check("arst_y",   a_y,   '0);
        check("arst_v",   a_v,   '0);
        check("arst_occ", a_occ, '0);
        check("arst_ptr", a_ptr, '0);
        tick();
        check("arst_hold_y", a_y, '0);
        #2;
        a_rst_n = 1'b1;
        a_e = 1'b1; a_mode = 1'b1; a_d = 8'h77;
        tick();
        check("post_rst_v",   a_v,   128'h8000);
        check("post_rst_y",   a_y,   128'h77 << 120);
        check("post_rst_ptr", a_ptr, 128'd1);
        a_e = 1'b0;

        // Non-reversed small instance
        b_mode = 1'b0; b_s = 2'd2; b_d = 1'b1; b_e = 1'b1;
        tick();
        check("b_v",   b_v,   128'b0100);
        check("b_y",   b_y,   128'b0100);
        check("b_occ", b_occ, 128'b0100);
        b_e = 1'b0;
        tick();
        check("b_v_idle", b_v, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/modulo_demux_seq.md
MODULO_DEMUX_SEQ -- requirements
Module: modulo_demux_seq

Parameters
REQ-001 SHALL provide parameter SEL_W, default 4, select width; channel count N = 2**SEL_W.
REQ-002 SHALL provide parameter DATA_W, default 1, data width per channel.
REQ-003 SHALL provide parameter REVERSE, default 1; 1 = select value c drives channel N-1-c (S=0 -> highest channel), 0 = select value c drives channel c.

Interface
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 E  input  1  write enable; a write is accepted on any rising edge with E=1 and CLR=0.
REQ-007 D  input  DATA_W  data to route.
REQ-008 S  input  SEL_W  channel select, used when MODE=0.
REQ-009 MODE  input  1  0 = addressed (S selects), 1 = scan (internal pointer selects).
REQ-010 CLR  input  1  synchronous clear.
REQ-011 Y  output  N*DATA_W  per-channel hold registers; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-012 V  output  N  per-channel write strobe, one-hot or zero.
REQ-013 OCC  output  N  per-channel sticky written flag.
REQ-014 PTR  output  SEL_W  current scan pointer.

Function
REQ-015 Selected value c SHALL be S when MODE=0, PTR when MODE=1, sampled at the accepting edge.
REQ-016 Target channel k SHALL be N-1-c if REVERSE=1, else c.
REQ-017 On an accepted write, Y slice k SHALL load D; all other slices SHALL hold.
REQ-018 On an accepted write, V SHALL equal one-hot(k) for exactly the following cycle; V SHALL be 0 in any cycle after an edge with no accepted write.
REQ-019 On an accepted write, OCC[k] SHALL set and remain set until CLR or reset.
REQ-020 Latency: Y, V, OCC SHALL reflect a write one clock after the accepting edge; no combinational path from D, S, E, or MODE to any output.
REQ-021 In MODE=1, each accepted write SHALL advance PTR by 1 modulo N (N-1 -> 0 wrap).
REQ-022 In MODE=0, and on edges with no accepted write, PTR SHALL hold.
REQ-023 MODE toggling SHALL NOT alter PTR, Y, or OCC; scan resumes from the held PTR.
REQ-024 Repeated writes to the same channel SHALL overwrite Y; the last write wins.
REQ-025 CLR=1 SHALL zero Y, V, OCC, and PTR at the edge, taking priority over a simultaneous E=1; that write is dropped.
REQ-026 E=0 SHALL leave every register except V unchanged, with V driven to 0.

Reset
REQ-027 RST_N=0 SHALL immediately, independent of CLK, force Y=0, V=0, OCC=0, PTR=0.
REQ-028 Outputs SHALL hold reset values while RST_N=0; the first write SHALL be accepted on the first rising edge with RST_N=1.
REQ-029 Reset asserted mid-scan SHALL discard PTR; scan restarts at 0 after release.

Verification (SEL_W=4, DATA_W=8, REVERSE=1 unless stated)
REQ-030 Addressed map: MODE=0, write D=0x10+c with S=c for c=0..15 -> Y slice 15-c = 0x10+c; V one-hot bit 15-c each cycle; OCC=0xFFFF at end.
REQ-031 Scan wrap: MODE=1, 17 consecutive writes D=1..17 -> PTR sequence 1..15, 0, 1; channel 15 holds 17, channels 14..0 hold 2..16.
REQ-032 Scan with gaps: MODE=1, E pattern 1,0,1 -> PTR 1,1,2; V = 0x8000, 0x0000, 0x4000.
REQ-033 CLR priority: OCC nonzero, E=1 and CLR=1 on the same edge -> Y=0, OCC=0, PTR=0, V=0 next cycle.
REQ-034 Async reset: RST_N driven low between edges mid-scan (PTR=5) -> all outputs 0 before the next edge; after release, first write lands on channel 15.
REQ-035 REVERSE=0, SEL_W=2, DATA_W=1: MODE=0, S=2, D=1 -> V=0b0100, Y=0b0100, OCC=0b0100.
